// File: rtl/isqrt_sched_pkg.sv
// Shared types and limits for the round-robin isqrt scheduler.
// The tag type is sized for the largest supported requester count so every
// block in the slice can carry a requester index without re-parameterising.
`timescale 1ns/1ps
package isqrt_sched_pkg;
    localparam int ISQRT_SCHED_MAX_REQ = 8;
    localparam int TAG_W = $clog2(ISQRT_SCHED_MAX_REQ);
    typedef logic [TAG_W-1:0] tag_t;
endpackage

// File: rtl/flip_flop_fifo_with_counter.sv
// Register-based FIFO with occupancy counter; o_data shows the head entry.
// Push while full and pop while empty are ignored.
// Ports: clk, rst_n, i_push/i_data, i_pop, o_data, o_empty, o_full, o_count.
`timescale 1ns/1ps
module flip_flop_fifo_with_counter #(
    parameter int width = 3,
    parameter int depth = 17,
    localparam int AW   = (depth > 1) ? $clog2(depth) : 1,
    localparam int CW   = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [width-1:0] i_data,
    input  logic             i_pop,
    output logic [width-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [CW-1:0]    o_count
);
    logic [width-1:0] r_mem [depth];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(depth - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_push = i_push && (r_cnt != CW'(depth));
    assign w_pop  = i_pop && (r_cnt != '0);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ptr_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(depth));
    assign o_count = r_cnt;
endmodule

// File: rtl/isqrt.sv
// Pipelined integer square root: y = floor(sqrt(x)) with a fixed latency of
// n_pipe_stages cycles from i_x_vld to o_y_vld.
// Ports: clk, rst_n (async, active-low), i_x_vld/i_x operand, o_y_vld/o_y result.
`timescale 1ns/1ps
module isqrt #(
    parameter int width         = 32,
    parameter int n_pipe_stages = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_x_vld,
    input  logic [width-1:0] i_x,
    output logic             o_y_vld,
    output logic [width-1:0] o_y
);
    // Highest power of four representable in width bits.
    localparam int TOP = (width % 2 == 0) ? width - 2 : width - 1;

    function automatic logic [width-1:0] sqrt_floor(input logic [width-1:0] x);
        logic [width-1:0] op;
        logic [width-1:0] root;
        logic [width-1:0] bitv;
        op        = x;
        root      = '0;
        bitv      = '0;
        bitv[TOP] = 1'b1;
        for (int i = 0; i <= TOP / 2; i++) begin
            if (op >= root + bitv) begin
                op   = op - (root + bitv);
                root = (root >> 1) + bitv;
            end else begin
                root = root >> 1;
            end
            bitv = bitv >> 2;
        end
        return root;
    endfunction

    logic [n_pipe_stages-1:0] r_vld;
    logic [width-1:0]         r_y [n_pipe_stages];

    // Root is formed on entry, then carried down a valid/data delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < n_pipe_stages; i++) begin
                r_y[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_x_vld;
            r_y[0]   <= i_x_vld ? sqrt_floor(i_x) : r_y[0];
            for (int i = 1; i < n_pipe_stages; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_y[i]   <= r_y[i-1];
            end
        end
    end

    assign o_y_vld = r_vld[n_pipe_stages-1];
    assign o_y     = r_y[n_pipe_stages-1];
endmodule

// File: rtl/isqrt_rr_scheduler_chk.sv
// Protocol checks on the tag FIFO that routes isqrt results back to requesters.
// Ports: clk, rst_n, FIFO push/pop/empty/full/count, isqrt output valid.
`timescale 1ns/1ps
module isqrt_rr_scheduler_chk #(
    parameter int depth = 17,
    localparam int CW   = $clog2(depth + 1)
) (
    input logic          clk,
    input logic          rst_n,
    input logic          i_push,
    input logic          i_pop,
    input logic          i_empty,
    input logic          i_full,
    input logic          i_y_vld,
    input logic [CW-1:0] i_count
);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(i_pop && i_empty))
        else $error("tag fifo popped while empty");
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && i_full))
        else $error("tag fifo pushed while full");
    a_empty_idle: assert property (@(posedge clk) disable iff (!rst_n) i_y_vld |-> !i_empty)
        else $error("isqrt result with no tag queued");
    a_count_rng: assert property (@(posedge clk) disable iff (!rst_n) i_count <= CW'(depth))
        else $error("tag fifo count out of range");
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational one-hot grant from the request vector,
// searching upward from a registered priority pointer with wrap-around.
// Ports: clk, rst_n (async, active-low), i_req[n] requests,
//        o_gnt[n] one-hot grant (forced low in reset), o_gnt_idx granted index.
`timescale 1ns/1ps
module rr_arbiter
    import isqrt_sched_pkg::*;
#(
    parameter int n = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] i_req,
    output logic [n-1:0] o_gnt,
    output tag_t         o_gnt_idx
);
    typedef logic [TAG_W:0] sum_t;

    tag_t                           r_ptr;
    tag_t                           w_idx;
    tag_t                           w_nxt;
    logic                           w_found;
    sum_t                           w_sum;
    logic [ISQRT_SCHED_MAX_REQ-1:0] w_req_pad;

    // First valid request at or after the pointer, modulo n.
    always_comb begin
        w_req_pad          = '0;
        w_req_pad[n-1:0]   = i_req;
        w_found            = 1'b0;
        w_idx              = '0;
        w_sum              = '0;
        for (int k = 0; k < n; k++) begin
            w_sum = sum_t'(r_ptr) + sum_t'(k);
            if (w_sum >= sum_t'(n)) begin
                w_sum = w_sum - sum_t'(n);
            end else begin
                w_sum = w_sum;
            end
            if (!w_found && w_req_pad[w_sum[TAG_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_sum[TAG_W-1:0];
            end else begin
                w_found = w_found;
            end
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next.
    always_comb begin
        if (w_idx == tag_t'(n - 1)) begin
            w_nxt = '0;
        end else begin
            w_nxt = w_idx + tag_t'(1);
        end
    end

    // Every grant is a handshake, so the pointer advances whenever one is found.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_nxt;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_gnt     = (rst_n && w_found) ? ({{(n-1){1'b0}}, 1'b1} << w_idx) : '0;
    assign o_gnt_idx = w_idx;
endmodule

// File: rtl/isqrt_rr_scheduler.sv
// Shares one pipelined isqrt among n_req requesters. A round-robin arbiter
// grants one request per cycle, the issue stage feeds isqrt, and a tag FIFO
// routes each result back to its requester in acceptance order.
// Ports: clk, rst (async, active-low), req_vld/req_x/req_rdy request side,
//        res_vld (one-hot) and res result side, busy while work is in flight.
`timescale 1ns/1ps
module isqrt_rr_scheduler
    import isqrt_sched_pkg::*;
#(
    parameter int n_req         = 3,
    parameter int width         = 32,
    parameter int isqrt_latency = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [n_req-1:0]       req_vld,
    input  logic [n_req*width-1:0] req_x,
    output logic [n_req-1:0]       req_rdy,
    output logic [n_req-1:0]       res_vld,
    output logic [width-1:0]       res,
    output logic                   busy
);
    localparam int FIFO_DEPTH = isqrt_latency + 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    tag_t             w_gnt_idx;
    logic             w_hs;
    logic [width-1:0] w_sel_x;
    logic             r_x_vld;
    logic [width-1:0] r_x;
    tag_t             r_tag;
    logic             w_y_vld;
    logic [width-1:0] w_y;
    tag_t             w_tag;
    logic             w_empty;
    logic             w_full;
    logic [CNT_W-1:0] w_count;
    logic [n_req-1:0] r_res_vld;
    logic [width-1:0] r_res;

    rr_arbiter #(.n(n_req)) u_arb (
        .clk       (clk),
        .rst_n     (rst),
        .i_req     (req_vld),
        .o_gnt     (req_rdy),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_hs = |req_rdy;

    // Operand of the granted requester.
    always_comb begin
        w_sel_x = '0;
        for (int i = 0; i < n_req; i++) begin
            if (tag_t'(i) == w_gnt_idx) begin
                w_sel_x = req_x[i*width +: width];
            end else begin
                w_sel_x = w_sel_x;
            end
        end
    end

    // Issue stage: operand and tag captured on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x_vld <= 1'b0;
            r_x     <= '0;
            r_tag   <= '0;
        end else begin
            r_x_vld <= w_hs;
            r_x     <= w_hs ? w_sel_x : r_x;
            r_tag   <= w_hs ? w_gnt_idx : r_tag;
        end
    end

    isqrt #(.width(width), .n_pipe_stages(isqrt_latency)) u_isqrt (
        .clk     (clk),
        .rst_n   (rst),
        .i_x_vld (r_x_vld),
        .i_x     (r_x),
        .o_y_vld (w_y_vld),
        .o_y     (w_y)
    );

    // Tag enters alongside the operand, so it lives exactly as long as the
    // operand is inside isqrt and occupancy never exceeds isqrt_latency.
    flip_flop_fifo_with_counter #(.width($bits(tag_t)), .depth(FIFO_DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (r_x_vld),
        .i_data  (r_tag),
        .i_pop   (w_y_vld),
        .o_data  (w_tag),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // Return stage: one-hot valid toward the owner, value held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res_vld <= '0;
            r_res     <= '0;
        end else begin
            r_res_vld <= w_y_vld ? ({{(n_req-1){1'b0}}, 1'b1} << w_tag) : '0;
            r_res     <= w_y_vld ? w_y : r_res;
        end
    end

    isqrt_rr_scheduler_chk #(.depth(FIFO_DEPTH)) u_chk (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (r_x_vld),
        .i_pop   (w_y_vld),
        .i_empty (w_empty),
        .i_full  (w_full),
        .i_y_vld (w_y_vld),
        .i_count (w_count)
    );

    assign res_vld = r_res_vld;
    assign res     = r_res;
    assign busy    = w_hs | r_x_vld | ~w_empty | (|r_res_vld);
endmodule

// File: tb/tb_isqrt_rr_scheduler.sv
`timescale 1ns/1ps
module tb_isqrt_rr_scheduler;
    localparam int N   = 3;
    localparam int W   = 32;
    localparam int L   = 16;
    localparam int LAT = L + 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_vld;
    logic [N*W-1:0] req_x;
    logic [N-1:0]   req_rdy;
    logic [N-1:0]   res_vld;
    logic [W-1:0]   res;
    logic           busy;

    typedef struct {
        int          due;
        int          tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   last_pop = -1;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    isqrt_rr_scheduler #(.n_req(N), .width(W), .isqrt_latency(L)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_x   (req_x),
        .req_rdy (req_rdy),
        .res_vld (res_vld),
        .res     (res),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_sqrt(input logic [31:0] x);
        logic [31:0] lo = 0;
        logic [31:0] hi = 65535;
        logic [31:0] mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) >> 1;
            if (64'(mid) * 64'(mid) <= 64'(x)) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    // Result monitor: exact-cycle one-hot valid and value, idle otherwise.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("res_vld", 32'(res_vld), 32'(1) << exp_q[0].tag);
                chk("res", res, exp_q[0].val);
                last_pop = cyc;
                void'(exp_q.pop_front());
            end else begin
                chk("res_vld_idle", 32'(res_vld), 32'd0);
            end
        end
    end

    task automatic drive(input logic [N-1:0] vld, input logic [31:0] x0, x1, x2,
                         input logic [31:0] r0, r1, r2, input logic [N-1:0] exp_rdy);
        exp_t e;
        @(negedge clk);
        req_vld = vld;
        req_x   = {x2, x1, x0};
        #1;
        chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
        if (exp_rdy != '0) begin
            chk("busy_hs", 32'(busy), 32'd1);
            e.due = cyc + LAT;
            e.tag = (exp_rdy == 3'b001) ? 0 : (exp_rdy == 3'b010) ? 1 : 2;
            e.val = (e.tag == 0) ? r0 : (e.tag == 1) ? r1 : r2;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 3 * LAT && !done; i++) begin
            @(negedge clk);
            req_vld = '0;
            #2;
            chk("busy", 32'(busy), 32'((exp_q.size() != 0) || (last_pop == cyc)));
            if (exp_q.size() == 0 && last_pop != cyc) done = 1'b1;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] e;
        int           start;
        rst     = 1'b0;
        req_vld = 3'b111;
        req_x   = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("rst_res_vld", 32'(res_vld), 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        req_vld = '0;
        mon_en  = 1'b1;
        #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // Full contention: grants rotate 0,1,2,...
        for (int i = 0; i < 9; i++) begin
            e = 3'b001;
            e = e << (i % 3);
            drive(3'b111, 32'd16, 32'd25, 32'd36, 32'd4, 32'd5, 32'd6, e);
        end
        // Fairness: pointer now at 0.
        drive(3'b100, 32'd0, 32'd0, 32'd49, 32'd0, 32'd0, 32'd7, 3'b100);
        drive(3'b101, 32'd64, 32'd0, 32'd49, 32'd8, 32'd0, 32'd7, 3'b001);
        drive(3'b101, 32'd64, 32'd0, 32'd49, 32'd8, 32'd0, 32'd7, 3'b100);
        drain();

        // Single request on requester 1 (pointer at 0).
        drive(3'b010, 32'd0, 32'd144, 32'd0, 32'd0, 32'd12, 32'd0, 3'b010);
        drain();

        // Back-to-back streaming from requester 0.
        for (int x = 0; x <= 40; x++) begin
            drive(3'b001, 32'(x), 32'd0, 32'd0, model_sqrt(32'(x)), 32'd0, 32'd0, 3'b001);
        end
        drain();

        // Boundaries on requester 2.
        drive(3'b100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b100);
        drive(3'b100, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 3'b100);
        drive(3'b100, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd65535, 3'b100);
        drain();

        // Reset mid-flight: five requests, reset at cycle 8 for two cycles.
        start = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            e = 3'b001;
            e = e << (i % 3);
            drive(3'b111, 32'd100, 32'd121, 32'd169, 32'd10, 32'd11, 32'd13, e);
        end
        @(negedge clk);
        req_vld = '0;
        for (int i = 0; i < 20 && cyc < start + 8; i++) @(negedge clk);
        rst     = 1'b0;
        req_vld = 3'b111;
        exp_q.delete();
        #1;
        chk("mid_rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("mid_rst_res_vld", 32'(res_vld), 32'd0);
        chk("mid_rst_res", res, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        chk("mid_rst_req_rdy2", 32'(req_rdy), 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        req_vld = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        drive(3'b001, 32'd81, 32'd0, 32'd0, 32'd9, 32'd0, 32'd0, 3'b001);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
